// File: rtl/midori64_round_key_gen.sv
// -----------------------------------------------------------------------------
// midori64_round_key_gen
//
// Purpose:
//   Produces the 17-word round-key sequence for a 3-share masked Midori64 core.
//   The 128-bit master key K = {K0, K1} arrives as three Boolean shares.
//   Word 0 and word 16 are the whitening key WK = K0 ^ K1. Words 1..15 are
//   alternately K0 and K1, starting with K0. Share 0 of words 1..15 also
//   carries the expanded round constant fetched from an external ROM.
//   Each share is processed independently, so the shares are never combined.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_start        load the key shares and begin a sequence (accepted in IDLE)
//   i_key_s0..s2   128-bit master-key shares, K0 = [127:64], K1 = [63:0]
//   o_rc_idx       round-constant index driven to the constant ROM
//   i_rc           16-bit round constant returned combinationally by the ROM
//   o_rk_valid     current round-key word is valid (RUN state)
//   i_rk_ready     downstream accepts the current word
//   o_rk_s0..s2    64-bit round-key word shares
//   o_rk_last      current word is the final whitening key (word 16)
//   o_busy         a sequence is in progress
//   o_done         one-cycle pulse after the final word is transferred
// -----------------------------------------------------------------------------
module midori64_round_key_gen (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [127:0] i_key_s0,
  input  logic [127:0] i_key_s1,
  input  logic [127:0] i_key_s2,
  output logic [3:0]   o_rc_idx,
  input  logic [15:0]  i_rc,
  output logic         o_rk_valid,
  input  logic         i_rk_ready,
  output logic [63:0]  o_rk_s0,
  output logic [63:0]  o_rk_s1,
  output logic [63:0]  o_rk_s2,
  output logic         o_rk_last,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [4:0] LAST_WORD = 5'd16;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [4:0]     r_cnt;
  logic [4:0]     w_cnt_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic           w_load;
  logic [127:0]   r_key_s0;
  logic [127:0]   r_key_s1;
  logic [127:0]   r_key_s2;

  logic           w_run;
  logic           w_wk_word;
  logic           w_const_word;
  logic [63:0]    w_rc_exp;
  logic [63:0]    w_sel_s0;
  logic [63:0]    w_sel_s1;
  logic [63:0]    w_sel_s2;

  // Spreads rc[i] onto bit 4*i, i.e. one constant bit per 4-bit cell LSB.
  function automatic logic [63:0] f_expand_rc(input logic [15:0] rc);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 16; i++) begin
      v[4*i] = rc[i];
    end
    return v;
  endfunction

  // Selects K0^K1 for whitening words, K0 for odd words and K1 for even words.
  function automatic logic [63:0] f_select(input logic [127:0] key,
                                           input logic         wk,
                                           input logic         odd);
    logic [63:0] v;
    if (wk) begin
      v = key[127:64] ^ key[63:0];
    end else if (odd) begin
      v = key[127:64];
    end else begin
      v = key[63:0];
    end
    return v;
  endfunction

  // Next-state, counter and load control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_cnt_nxt   = 5'd0;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_rk_ready) begin
          if (r_cnt == LAST_WORD) begin
            // Final transfer: leave RUN and park the counter at 0.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 5'd0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + 5'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  // State, word counter and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Key share registers, loaded only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s0 <= 128'd0;
      r_key_s1 <= 128'd0;
      r_key_s2 <= 128'd0;
    end else if (w_load) begin
      r_key_s0 <= i_key_s0;
      r_key_s1 <= i_key_s1;
      r_key_s2 <= i_key_s2;
    end else begin
      r_key_s0 <= r_key_s0;
      r_key_s1 <= r_key_s1;
      r_key_s2 <= r_key_s2;
    end
  end

  assign w_run        = (r_state == ST_RUN);
  assign w_wk_word    = (r_cnt == 5'd0) || (r_cnt == LAST_WORD);
  assign w_const_word = !w_wk_word;
  assign w_rc_exp     = f_expand_rc(i_rc);

  assign w_sel_s0 = f_select(r_key_s0, w_wk_word, r_cnt[0]);
  assign w_sel_s1 = f_select(r_key_s1, w_wk_word, r_cnt[0]);
  assign w_sel_s2 = f_select(r_key_s2, w_wk_word, r_cnt[0]);

  // Round-key word and ROM index; everything is zero outside RUN.
  always_comb begin
    o_rk_s0  = 64'd0;
    o_rk_s1  = 64'd0;
    o_rk_s2  = 64'd0;
    o_rc_idx = 4'd0;
    if (w_run) begin
      o_rk_s1 = w_sel_s1;
      o_rk_s2 = w_sel_s2;
      if (w_const_word) begin
        // Constant only enters share 0; cnt is 1..15 here so cnt-1 fits 4 bits.
        o_rk_s0  = w_sel_s0 ^ w_rc_exp;
        o_rc_idx = r_cnt[3:0] - 4'd1;
      end else begin
        o_rk_s0  = w_sel_s0;
        o_rc_idx = 4'd0;
      end
    end else begin
      o_rk_s0  = 64'd0;
      o_rc_idx = 4'd0;
    end
  end

  assign o_rk_valid = w_run;
  assign o_busy     = w_run;
  assign o_rk_last  = w_run && (r_cnt == LAST_WORD);
  assign o_done     = r_done;

endmodule

// File: doc/midori64_round_key_gen.md
MIDORI64_ROUND_KEY_GEN -- requirements
Module: midori64_round_key_gen

Interface
REQ-001 Parameters: none; the share count is fixed at 3 and the word count at 17.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to load key shares and begin a key sequence.
REQ-005 key_s0, key_s1, key_s2  input  128 each  Boolean shares of the master key K; K0 = bits [127:64], K1 = bits [63:0].
REQ-006 rc_idx  output  4  round-constant index presented to the external constant ROM.
REQ-007 rc  input  16  round constant returned combinationally by the ROM for rc_idx.
REQ-008 rk_valid  output  1  the current round-key word is valid.
REQ-009 rk_ready  input  1  the downstream key-addition stage accepts the word.
REQ-010 rk_s0, rk_s1, rk_s2  output  64 each  round-key word shares, consumed by the 64-bit share XOR stage.
REQ-011 rk_last  output  1  the current word is word 16, the final whitening key.
REQ-012 busy  output  1  a sequence is in progress.
REQ-013 done  output  1  one-cycle pulse at the end of a sequence.

Function
REQ-014 The block SHALL have two states: IDLE and RUN.
REQ-015 In IDLE with start=1, the block SHALL register all three key shares, clear the 5-bit word counter cnt to 0 and enter RUN on the same edge.
REQ-016 In RUN, start SHALL be ignored and the key registers SHALL hold their values.
REQ-017 In RUN, rk_valid SHALL be 1 and busy SHALL be 1; in IDLE, both SHALL be 0 and rk_s0/rk_s1/rk_s2 SHALL be forced to 0.
REQ-018 The first word (cnt=0) SHALL become valid in the cycle after the start edge.
REQ-019 For cnt=0 and cnt=16, share j SHALL equal K0_sj ^ K1_sj (whitening key WK).
REQ-020 For cnt=n with 1<=n<=15, share j SHALL equal K((n-1) mod 2)_sj.
REQ-021 For cnt=n with 1<=n<=15, share 0 SHALL additionally be XORed with expand(rc), and shares 1 and 2 SHALL NOT be XORed with any constant.
REQ-022 expand(rc) SHALL be the 64-bit word with bit 4*i equal to rc[i] for i=0..15 and all other bits 0.
REQ-023 rc_idx SHALL equal cnt-1 for 1<=cnt<=15 and 0 otherwise.
REQ-024 The rk outputs SHALL be combinational from the registered key shares, cnt and rc, with no further latency.
REQ-025 A transfer SHALL occur on any edge where rk_valid=1 and rk_ready=1; cnt SHALL increment only on a transfer.
REQ-026 While rk_valid=1 and rk_ready=0, cnt, rc_idx and all rk outputs SHALL hold stable.
REQ-027 rk_last SHALL be 1 exactly when the block is in RUN and cnt=16.
REQ-028 A transfer at cnt=16 SHALL return the block to IDLE and assert done for exactly the next cycle.
REQ-029 A start asserted in the done cycle SHALL be accepted, because the block is already in IDLE.
REQ-030 cnt SHALL never exceed 16 and SHALL never wrap.
REQ-031 Each sequence SHALL transfer exactly 17 words.

Reset
REQ-032 rst_n=0 SHALL, asynchronously, put the block in IDLE and clear cnt and all key registers to 0.
REQ-033 During reset, rk_valid, rk_last, busy and done SHALL be 0, and rc_idx and the rk outputs SHALL be 0.
REQ-034 A reset mid-sequence SHALL abort the sequence with no done pulse.
REQ-035 After reset is released, the block SHALL require a new start before producing words.

Verification
REQ-036 Whitening scenario: key_s0=0x687ded3b3c85b3f35b1009863e2a8cbf, key_s1=key_s2=0, rk_ready=1, start pulse -> word 0: rk_s0=0x336de4bd02af3f4c, rk_s1=rk_s2=0.
REQ-037 Constant scenario: same key, ROM stub rc=0x8001 -> word 1: rk_s0=0x787ded3b3c85b3f2, rc_idx=0; word 2: rk_s0=0x4b1009863e2a8cbe, rc_idx=1.
REQ-038 Sequence-end scenario: rk_ready held at 1 -> 17 consecutive transfers, rk_last=1 only on the 17th, done pulses the next cycle, busy=0 afterwards.
REQ-039 Backpressure scenario: rk_ready=0 for 5 cycles at cnt=3 -> outputs, rc_idx=2 and cnt held; the sequence resumes on rk_ready=1.
REQ-040 Masking scenario: random shares whose XOR equals the key above -> the XOR of rk_s0, rk_s1 and rk_s2 per word equals the unmasked result; start pulses while busy are ignored.
REQ-041 Reset scenario: rst_n=0 asserted at cnt=7 -> all outputs 0 immediately, no done; the next start restarts at word 0.
